// File: rtl/dma_if_pkg.sv
// Shared types and constants for the DMA memory responder.
package dma_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_ACK  = 3'd2,
    ST_RD_HOLD = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_WR_ACK  = 3'd5,
    ST_WR_HOLD = 3'd6
  } dma_state_e;

  localparam int          LAT_W      = 4;
  localparam logic [31:0] DEADBEEF   = 32'hDEAD_BEEF;
  localparam logic [63:0] READY_ONE  = 64'd1;
  localparam logic [63:0] READY_ZERO = 64'd0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dma_mem_ram.sv
// 2^AW x 32 word memory: port A is the responder side (combinational read,
// synchronous write), port B is the host side (registered read, write-enable).
module dma_mem_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] a_addr_i,
  input  logic          a_we_i,
  input  logic [31:0]   a_wdata_i,
  output logic [31:0]   a_rdata_o,
  input  logic [AW-1:0] b_addr_i,
  input  logic          b_we_i,
  input  logic [31:0]   b_wdata_i,
  output logic [31:0]   b_rdata_o
);

  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] b_rdata_q;

  // Contents are deliberately not reset; the two write ports never collide
  // because the host side is only enabled while the responder is idle.
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end else if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_rdata_q <= 32'd0;
    end else begin
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = mem_q[a_addr_i];
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/dma_mem_responder.sv
// Memory-side responder serving beat-by-beat read/write requests from a local
// word memory, with a host port for preload and inspection.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no beat in flight; host writes allowed
// ST_RD_WAIT | counting down read latency for the latched address
// ST_RD_ACK  | read_ready pulse, read_data valid
// ST_RD_HOLD | waiting for finish_read (next beat) or read_enable low
// ST_WR_WAIT | counting down write latency
// ST_WR_ACK  | write_ready pulse, memory written from live write bus
// ST_WR_HOLD | waiting for finish_write (next beat) or write_enable low
module dma_mem_responder
  import dma_if_pkg::*;
#(
  parameter int          AW     = 12,
  parameter logic [63:0] BASE   = 64'h0,
  parameter int          RD_LAT = 2,
  parameter int          WR_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read_enable,
  input  logic [63:0]   read_addr,
  input  logic          finish_read,
  output logic [31:0]   read_data,
  output logic [63:0]   read_ready,
  input  logic          write_enable,
  input  logic [63:0]   write_addr,
  input  logic [31:0]   write_data,
  input  logic          finish_write,
  output logic [63:0]   write_ready,
  input  logic          done,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  output logic [31:0]   rd_beats,
  output logic [31:0]   wr_beats,
  output logic [15:0]   addr_err,
  output logic          done_seen
);

  localparam logic [LAT_W-1:0] RD_LAT_C = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] WR_LAT_C = LAT_W'(WR_LAT);
  localparam logic [63:0]      SPAN     = 64'd1 << (AW + 2);

  dma_state_e       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q, addr_d;
  logic [31:0]      read_data_q, read_data_d;
  logic [31:0]      rd_beats_q, rd_beats_d;
  logic [31:0]      wr_beats_q, wr_beats_d;
  logic [15:0]      addr_err_q, addr_err_d;
  logic             done_seen_q, done_seen_d;

  logic [63:0]   rd_off, wr_off;
  logic          rd_in_range, wr_in_range;
  logic [AW-1:0] a_idx;
  logic          a_we;
  logic [31:0]   a_rdata;

  // Reads use the latched beat address; writes use the live bus at the ACK edge.
  assign rd_off      = addr_q - BASE;
  assign wr_off      = write_addr - BASE;
  assign rd_in_range = (addr_q >= BASE) && (rd_off < SPAN) && (addr_q[1:0] == 2'b00);
  assign wr_in_range = (write_addr >= BASE) && (wr_off < SPAN) && (write_addr[1:0] == 2'b00);
  assign a_idx       = (state_q == ST_WR_ACK) ? wr_off[AW+1:2] : rd_off[AW+1:2];
  assign a_we        = (state_q == ST_WR_ACK) && wr_in_range;

  dma_mem_ram #(.AW(AW)) u_ram (
    .clk       (clk),
    .reset     (reset),
    .a_addr_i  (a_idx),
    .a_we_i    (a_we),
    .a_wdata_i (write_data),
    .a_rdata_o (a_rdata),
    .b_addr_i  (host_addr),
    .b_we_i    (host_we && (state_q == ST_IDLE)),
    .b_wdata_i (host_wdata),
    .b_rdata_o (host_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    read_data_d = read_data_q;
    rd_beats_d  = rd_beats_q;
    wr_beats_d  = wr_beats_q;
    addr_err_d  = addr_err_q;
    done_seen_d = done_seen_q | done;

    unique case (state_q)
      ST_IDLE: begin
        if (read_enable) begin
          addr_d  = read_addr;
          cnt_d   = RD_LAT_C;
          state_d = ST_RD_WAIT;
        end else if (write_enable) begin
          addr_d  = write_addr;
          cnt_d   = WR_LAT_C;
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          read_data_d = rd_in_range ? a_rdata : DEADBEEF;
          state_d     = ST_RD_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RD_ACK: begin
        rd_beats_d = rd_beats_q + 32'd1;
        if (!rd_in_range) addr_err_d = sat_inc16(addr_err_q);
        state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (!read_enable) begin
          state_d = ST_IDLE;
        end else if (finish_read) begin
          addr_d  = read_addr;
          cnt_d   = RD_LAT_C;
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_ACK: begin
        wr_beats_d = wr_beats_q + 32'd1;
        if (!wr_in_range) addr_err_d = sat_inc16(addr_err_q);
        state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        if (!write_enable) begin
          state_d = ST_IDLE;
        end else if (finish_write) begin
          addr_d  = write_addr;
          cnt_d   = WR_LAT_C;
          state_d = ST_WR_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      read_data_q <= '0;
      rd_beats_q  <= '0;
      wr_beats_q  <= '0;
      addr_err_q  <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      read_data_q <= read_data_d;
      rd_beats_q  <= rd_beats_d;
      wr_beats_q  <= wr_beats_d;
      addr_err_q  <= addr_err_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign read_data   = read_data_q;
  assign read_ready  = (state_q == ST_RD_ACK) ? READY_ONE : READY_ZERO;
  assign write_ready = (state_q == ST_WR_ACK) ? READY_ONE : READY_ZERO;
  assign rd_beats    = rd_beats_q;
  assign wr_beats    = wr_beats_q;
  assign addr_err    = addr_err_q;
  assign done_seen   = done_seen_q;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Scenario bench for dma_mem_responder: expected beats are queued when driven
// and popped when the responder acknowledges them.
module tb_dma_mem_responder;

  localparam int          AW     = 8;
  localparam logic [63:0] BASE   = 64'h0000_0000_1000_0000;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;
  localparam int          TMO    = 40;

  logic          clk;
  logic          reset;
  logic          read_enable;
  logic [63:0]   read_addr;
  logic          finish_read;
  logic [31:0]   read_data;
  logic [63:0]   read_ready;
  logic          write_enable;
  logic [63:0]   write_addr;
  logic [31:0]   write_data;
  logic          finish_write;
  logic [63:0]   write_ready;
  logic          done;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [31:0]   host_rdata;
  logic [31:0]   rd_beats;
  logic [31:0]   wr_beats;
  logic [15:0]   addr_err;
  logic          done_seen;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [0:(1<<AW)-1];

  dma_mem_responder #(.AW(AW), .BASE(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .read_addr(read_addr), .finish_read(finish_read),
    .read_data(read_data), .read_ready(read_ready),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .finish_write(finish_write), .write_ready(write_ready),
    .done(done),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .rd_beats(rd_beats), .wr_beats(wr_beats), .addr_err(addr_err), .done_seen(done_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic host_write(input int idx, input logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = AW'(idx); host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    model[idx] = d;
  endtask

  task automatic host_read(input int idx, output logic [31:0] d);
    @(negedge clk);
    host_addr = AW'(idx);
    @(negedge clk);
    d = host_rdata;
  endtask

  // Counts negedges from the drive point until read_ready; also flags any write_ready.
  task automatic wait_rd(output int lat, output bit seen, output bit other);
    lat = 0; seen = 1'b0; other = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      finish_read = 1'b0;
      lat++;
      if (write_ready !== 64'd0) other = 1'b1;
      if (read_ready === 64'd1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_wr(output int lat, output bit seen, output bit other);
    lat = 0; seen = 1'b0; other = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      finish_write = 1'b0;
      lat++;
      if (read_ready !== 64'd0) other = 1'b1;
      if (write_ready === 64'd1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    read_enable = 0; read_addr = '0; finish_read = 0;
    write_enable = 0; write_addr = '0; write_data = '0; finish_write = 0;
    done = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    total++; if (read_ready !== 64'd0) begin bad++; $display("FAIL reset read_ready: got %h exp 0", read_ready); end
    total++; if (write_ready !== 64'd0) begin bad++; $display("FAIL reset write_ready: got %h exp 0", write_ready); end
    total++; if (read_data !== 32'd0) begin bad++; $display("FAIL reset read_data: got %h exp 0", read_data); end
    total++; if (host_rdata !== 32'd0) begin bad++; $display("FAIL reset host_rdata: got %h exp 0", host_rdata); end
    total++; if ({rd_beats, wr_beats, addr_err, done_seen} !== 81'd0) begin bad++; $display("FAIL reset counters: got %h %h %h %b exp 0", rd_beats, wr_beats, addr_err, done_seen); end
    reset = 1'b0;
  endtask

  task automatic test_read_burst();
    int lat; bit seen, other;
    logic [31:0] e;
    for (int i = 0; i < 8; i++) host_write(i, 32'(i + 1));
    for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
    @(negedge clk);
    read_enable = 1'b1; read_addr = BASE;
    for (int b = 0; b < 4; b++) begin
      wait_rd(lat, seen, other);
      total++; if (!seen || lat != RD_LAT + 2) begin bad++; $display("FAIL rd_burst latency beat%0d: got %0d seen=%0b exp %0d", b, lat, seen, RD_LAT + 2); end
      e = exp_q.pop_front();
      total++; if (read_data !== e) begin bad++; $display("FAIL rd_burst data beat%0d: got %h exp %h", b, read_data, e); end
      @(negedge clk);
      total++; if (read_ready !== 64'd0) begin bad++; $display("FAIL rd_burst pulse width beat%0d: got %h exp 0", b, read_ready); end
      if (b < 3) begin
        finish_read = 1'b1;
        read_addr = BASE + 64'(4 * (b + 1));
      end else begin
        read_enable = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    total++; if (rd_beats !== 32'd4) begin bad++; $display("FAIL rd_burst rd_beats: got %0d exp 4", rd_beats); end
  endtask

  task automatic test_write_burst();
    int lat; bit seen, other;
    logic [31:0] got, e;
    @(negedge clk);
    write_enable = 1'b1; write_addr = BASE + 64'd8; write_data = 32'hA;
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(32'(32'hA + b));
      model[2 + b] = 32'(32'hA + b);
      wait_wr(lat, seen, other);
      total++; if (!seen || lat != WR_LAT + 2) begin bad++; $display("FAIL wr_burst latency beat%0d: got %0d seen=%0b exp %0d", b, lat, seen, WR_LAT + 2); end
      @(negedge clk);
      total++; if (write_ready !== 64'd0) begin bad++; $display("FAIL wr_burst pulse width beat%0d: got %h exp 0", b, write_ready); end
      if (b < 2) begin
        finish_write = 1'b1;
        write_addr = BASE + 64'(8 + 4 * (b + 1));
        write_data = 32'(32'hA + b + 1);
      end else begin
        write_enable = 1'b0;
      end
    end
    for (int i = 2; i < 5; i++) begin
      host_read(i, got);
      e = exp_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL wr_burst host_rdata idx%0d: got %h exp %h", i, got, e); end
    end
    total++; if (wr_beats !== 32'd3) begin bad++; $display("FAIL wr_burst wr_beats: got %0d exp 3", wr_beats); end
  endtask

  task automatic test_read_priority();
    int lat; bit seen, other;
    logic [31:0] got, e;
    exp_q.push_back(model[5]);
    @(negedge clk);
    read_enable = 1'b1; read_addr = BASE + 64'd20;
    write_enable = 1'b1; write_addr = BASE + 64'd36; write_data = 32'h55AA_0009;
    wait_rd(lat, seen, other);
    total++; if (!seen || other || lat != RD_LAT + 2) begin bad++; $display("FAIL prio read first: lat=%0d seen=%0b wr_seen=%0b exp lat %0d seen=1 wr_seen=0", lat, seen, other, RD_LAT + 2); end
    e = exp_q.pop_front();
    total++; if (read_data !== e) begin bad++; $display("FAIL prio read data: got %h exp %h", read_data, e); end
    @(negedge clk);
    read_enable = 1'b0;
    model[9] = 32'h55AA_0009;
    exp_q.push_back(model[9]);
    wait_wr(lat, seen, other);
    total++; if (!seen || lat != WR_LAT + 3) begin bad++; $display("FAIL prio write after idle: lat=%0d seen=%0b exp lat %0d", lat, seen, WR_LAT + 3); end
    @(negedge clk);
    write_enable = 1'b0;
    host_read(9, got);
    e = exp_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL prio write data: got %h exp %h", got, e); end
    total++; if (rd_beats !== 32'd5 || wr_beats !== 32'd4) begin bad++; $display("FAIL prio beats: got rd=%0d wr=%0d exp rd=5 wr=4", rd_beats, wr_beats); end
  endtask

  task automatic test_out_of_range();
    int lat; bit seen, other;
    logic [31:0] got, e;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    read_enable = 1'b1; read_addr = BASE + (64'd4 << AW);
    wait_rd(lat, seen, other);
    e = exp_q.pop_front();
    total++; if (!seen || read_data !== e) begin bad++; $display("FAIL oor read data: got %h seen=%0b exp %h", read_data, seen, e); end
    @(negedge clk);
    read_enable = 1'b0;
    @(negedge clk);
    total++; if (addr_err !== 16'd1) begin bad++; $display("FAIL oor read addr_err: got %0d exp 1", addr_err); end
    write_enable = 1'b1; write_addr = BASE + 64'd2; write_data = 32'hBAD0_0002;
    wait_wr(lat, seen, other);
    total++; if (!seen) begin bad++; $display("FAIL oor write handshake: got seen=0 exp seen=1"); end
    @(negedge clk);
    write_enable = 1'b0;
    @(negedge clk);
    total++; if (addr_err !== 16'd2) begin bad++; $display("FAIL oor write addr_err: got %0d exp 2", addr_err); end
    host_read(0, got);
    total++; if (got !== model[0]) begin bad++; $display("FAIL oor write dropped: got %h exp %h", got, model[0]); end
    total++; if (rd_beats !== 32'd6 || wr_beats !== 32'd5) begin bad++; $display("FAIL oor beats: got rd=%0d wr=%0d exp rd=6 wr=5", rd_beats, wr_beats); end
  endtask

  task automatic test_done_flag();
    total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL done before pulse: got %b exp 0", done_seen); end
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL done set: got %b exp 1", done_seen); end
    repeat (5) @(negedge clk);
    total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL done sticky: got %b exp 1", done_seen); end
  endtask

  task automatic test_reset_mid_burst();
    int lat; bit seen, other, leak;
    logic [31:0] got, e;
    @(negedge clk);
    read_enable = 1'b1; read_addr = BASE + 64'd4;
    @(negedge clk);
    host_we = 1'b1; host_addr = AW'(6); host_wdata = 32'hFFFF_0006;
    @(negedge clk);
    host_we = 1'b0;
    reset = 1'b1; read_enable = 1'b0;
    @(negedge clk);
    total++; if (read_ready !== 64'd0) begin bad++; $display("FAIL midrst read_ready: got %h exp 0", read_ready); end
    total++; if ({rd_beats, wr_beats, addr_err, done_seen} !== 81'd0) begin bad++; $display("FAIL midrst counters: got %h %h %h %b exp 0", rd_beats, wr_beats, addr_err, done_seen); end
    total++; if (read_data !== 32'd0) begin bad++; $display("FAIL midrst read_data: got %h exp 0", read_data); end
    reset = 1'b0;
    leak = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (read_ready !== 64'd0) leak = 1'b1;
    end
    total++; if (leak) begin bad++; $display("FAIL midrst stray ready: got 1 exp 0"); end
    for (int i = 0; i < 8; i++) begin
      host_read(i, got);
      total++; if (got !== model[i]) begin bad++; $display("FAIL midrst mem idx%0d: got %h exp %h", i, got, model[i]); end
    end
    exp_q.push_back(model[3]);
    @(negedge clk);
    read_enable = 1'b1; read_addr = BASE + 64'd12;
    wait_rd(lat, seen, other);
    total++; if (!seen || lat != RD_LAT + 2) begin bad++; $display("FAIL midrst restart latency: got %0d seen=%0b exp %0d", lat, seen, RD_LAT + 2); end
    e = exp_q.pop_front();
    total++; if (read_data !== e) begin bad++; $display("FAIL midrst restart data: got %h exp %h", read_data, e); end
    @(negedge clk);
    read_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_read_priority();
    test_out_of_range();
    test_done_flag();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
